control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Branch/jump resolution unit for the RV32I core.
- Takes the one-hot decoded instruction bus from the decoder, the current PC, the sign-extended immediate and the register-file operands.
- Requests the source registers it needs, evaluates branch conditions and jump targets, and produces the registered next PC with a redirect flag for the fetch stage.

Parameters:
- XLEN, 32, data/address width of pc, operands, immediate, next_pc.
- PC_INC, 4, sequential PC increment for fall-through.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- instr_bus  input  37  one-hot decoded instruction (map below).
- pc  input  XLEN  PC of the instruction on instr_bus.
- rs1_value  input  XLEN  signed rs1 operand.
- rs2_value  input  XLEN  signed rs2 operand.
- rs1_valid  input  1  rs1_value is valid this cycle.
- rs2_valid  input  1  rs2_value is valid this cycle.
- imm  input  XLEN  signed, sign-extended immediate.
- rs1_read  output  1  combinational: instruction needs rs1.
- rs2_read  output  1  combinational: instruction needs rs2.
- next_pc  output  XLEN  registered next PC.
- pc_j_valid  output  1  registered: next_pc is a taken branch/jump target.

Behaviour:
- instr_bus bit map:
  - 0-9: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND.
  - 10-18: ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI.
  - 19-23: LB LH LW LBU LHU.
  - 24-26: SB SH SW.
  - 27-32: BEQ BNE BLT BGE BLTU BGEU.
  - 33: JAL. 34: JALR. 35: LUI. 36: AUIPC.
- rs1_read = 1 for bits 0-34 except 33 (JAL). 0 for JAL, LUI, AUIPC, and for zero/multi-hot buses.
- rs2_read = 1 for bits 0-9, 24-26, 27-32.
- Operands ready (ready) = (!rs1_read | rs1_valid) & (!rs2_read | rs2_valid).
- Branch conditions:
  - BEQ: rs1 == rs2. BNE: rs1 != rs2.
  - BLT / BGE: signed compare (< / >=).
  - BLTU / BGEU: unsigned compare (< / >=).
- Targets:
  - Branch and JAL: pc + imm.
  - JALR: (rs1_value + imm) with bit 0 cleared.
  - All additions modulo 2^XLEN.
- Registered update on rising clk; latency one cycle from inputs to next_pc/pc_j_valid:
  - rst_n == 0: next_pc <= 0, pc_j_valid <= 0. Reset wins over any instruction, including mid-stall.
  - Bus zero or more than one bit set (illegal): next_pc <= pc + PC_INC, pc_j_valid <= 0.
  - Needed operand not ready (stall): next_pc <= pc, pc_j_valid <= 0.
  - JAL, JALR (ready): next_pc <= target, pc_j_valid <= 1.
  - Branch taken: next_pc <= target, pc_j_valid <= 1.
  - Branch not taken: next_pc <= pc + PC_INC, pc_j_valid <= 0.
  - All other legal instructions: next_pc <= pc + PC_INC, pc_j_valid <= 0.
- rs1_read/rs2_read are purely combinational from instr_bus and are unaffected by reset.
- No internal state other than the two output registers.

Optional Feature:
- MISALIGN_CHECK_EN:
  - When defined, adds output port misaligned (1 bit, registered, reset 0).
  - For a taken branch/JAL/JALR whose target has bit 0 set: misaligned <= 1, pc_j_valid <= 0, next_pc <= pc + PC_INC.
  - Otherwise misaligned <= 0.
- Undefined: port absent; targets are used unchecked.

Test Plan:
- Reset: rst_n=0 for one edge with BEQ on bus -> next_pc=0, pc_j_valid=0.
- BEQ taken: instr_bus[27]=1, pc=1, rs1=rs2=1, both valid, imm=5 -> after one edge next_pc=6, pc_j_valid=1; rs1_read=rs2_read=1 immediately.
- BLT vs BLTU: rs1=-1, rs2=1, pc=100, imm=-8.
  - BLT -> next_pc=92, pc_j_valid=1.
  - BLTU -> next_pc=104, pc_j_valid=0.
- JALR: instr_bus[34]=1, rs1=0x1003, imm=4, rs1_valid=1 -> next_pc=0x1006, pc_j_valid=1, rs2_read=0.
- Stall: BNE with rs2_valid=0, pc=40 -> next_pc=40, pc_j_valid=0. Assert rs2_valid next cycle with rs1!=rs2, imm=12 -> next_pc=52, pc_j_valid=1.
- Fall-through/illegal:
  - ADDI at pc=8 -> next_pc=12, pc_j_valid=0.
  - instr_bus=0 at pc=8 -> next_pc=12, pc_j_valid=0, rs1_read=rs2_read=0.

Source files
------------

// File: rtl/control_unit_if.sv
// Handshake bundle between the decode/regfile side and the branch/jump resolution unit.
// The misaligned flag exists only when MISALIGN_CHECK_EN is defined.
interface control_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic [36:0]     instr_bus;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_value;
  logic [XLEN-1:0] rs2_value;
  logic            rs1_valid;
  logic            rs2_valid;
  logic [XLEN-1:0] imm;
  logic            rs1_read;
  logic            rs2_read;
  logic [XLEN-1:0] next_pc;
  logic            pc_j_valid;
`ifdef MISALIGN_CHECK_EN
  logic            misaligned;
`endif

  modport master (
    output instr_bus, pc, rs1_value, rs2_value, rs1_valid, rs2_valid, imm,
    input  rs1_read, rs2_read, next_pc, pc_j_valid
`ifdef MISALIGN_CHECK_EN
    , input misaligned
`endif
  );

  modport slave (
    input  instr_bus, pc, rs1_value, rs2_value, rs1_valid, rs2_valid, imm,
    output rs1_read, rs2_read, next_pc, pc_j_valid
`ifdef MISALIGN_CHECK_EN
    , output misaligned
`endif
  );
endinterface

// File: rtl/control_unit.sv
// RV32I branch/jump resolution: requests operands, resolves branches/jumps, registers next PC.
// Optional MISALIGN_CHECK_EN suppresses redirects to targets with bit 0 set.
module control_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PC_INC = 4
) (
  input logic         clk,
  input logic         rst_n,
  control_unit_if.slave cu
);

  logic [36:0]     ib;
  logic            one_hot;
  logic            need_rs1;
  logic            need_rs2;
  logic            ready;
  logic            eq;
  logic            lt_s;
  logic            lt_u;
  logic            taken;
  logic            jump;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc_d, next_pc_q;
  logic            pc_j_valid_d, pc_j_valid_q;
`ifdef MISALIGN_CHECK_EN
  logic            misaligned_d, misaligned_q;
`endif

  assign ib      = cu.instr_bus;
  assign one_hot = (ib != '0) && ((ib & (ib - 37'd1)) == '0);

  // Gating with one_hot makes zero and multi-hot buses request nothing.
  assign need_rs1 = one_hot & (ib[34] | (|ib[32:0]));
  assign need_rs2 = one_hot & ((|ib[9:0]) | (|ib[32:24]));
  assign ready    = (~need_rs1 | cu.rs1_valid) & (~need_rs2 | cu.rs2_valid);

  assign eq   = (cu.rs1_value == cu.rs2_value);
  assign lt_s = ($signed(cu.rs1_value) < $signed(cu.rs2_value));
  assign lt_u = (cu.rs1_value < cu.rs2_value);

  assign taken = one_hot & ((ib[27] & eq)   | (ib[28] & ~eq)   |
                            (ib[29] & lt_s) | (ib[30] & ~lt_s) |
                            (ib[31] & lt_u) | (ib[32] & ~lt_u));
  assign jump  = one_hot & (ib[33] | ib[34] | taken);

  assign seq_pc    = cu.pc + XLEN'(PC_INC);
  assign br_target = cu.pc + cu.imm;
  assign jalr_sum  = cu.rs1_value + cu.imm;
  assign target    = ib[34] ? {jalr_sum[XLEN-1:1], 1'b0} : br_target;

  always_comb begin
    next_pc_d    = seq_pc;
    pc_j_valid_d = 1'b0;
`ifdef MISALIGN_CHECK_EN
    misaligned_d = 1'b0;
`endif
    if (one_hot) begin
      if (!ready) begin
        next_pc_d = cu.pc;
      end else if (jump) begin
`ifdef MISALIGN_CHECK_EN
        if (target[0]) begin
          misaligned_d = 1'b1;
        end else begin
          next_pc_d    = target;
          pc_j_valid_d = 1'b1;
        end
`else
        next_pc_d    = target;
        pc_j_valid_d = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      next_pc_q    <= '0;
      pc_j_valid_q <= 1'b0;
`ifdef MISALIGN_CHECK_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      next_pc_q    <= next_pc_d;
      pc_j_valid_q <= pc_j_valid_d;
`ifdef MISALIGN_CHECK_EN
      misaligned_q <= misaligned_d;
`endif
    end
  end

  assign cu.rs1_read   = need_rs1;
  assign cu.rs2_read   = need_rs2;
  assign cu.next_pc    = next_pc_q;
  assign cu.pc_j_valid = pc_j_valid_q;
`ifdef MISALIGN_CHECK_EN
  assign cu.misaligned = misaligned_q;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: expected outputs are queued when stimulus is driven
// and popped one clock later when the registered outputs are sampled.
module tb_control_unit;

  typedef struct {
    string       tag;
    logic [31:0] npc;
    logic        jv;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t sb[$];

  control_unit_if #(.XLEN(32)) cu_bus ();

  control_unit #(
    .XLEN  (32),
    .PC_INC(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .cu   (cu_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [36:0] bit_of(input int i);
    logic [36:0] one;
    one = 37'd1;
    return one << i;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Drive one instruction, check combinational reads, then check registered outputs.
  task automatic step(input string tag, input logic [36:0] b, input logic [31:0] p,
                      input logic [31:0] r1, input logic [31:0] r2, input logic v1,
                      input logic v2, input logic [31:0] im, input logic [31:0] enpc,
                      input logic ejv, input logic er1, input logic er2);
    exp_t e;
    exp_t got;
    cu_bus.instr_bus = b;
    cu_bus.pc        = p;
    cu_bus.rs1_value = r1;
    cu_bus.rs2_value = r2;
    cu_bus.rs1_valid = v1;
    cu_bus.rs2_valid = v2;
    cu_bus.imm       = im;
    e.tag = tag;
    e.npc = enpc;
    e.jv  = ejv;
    sb.push_back(e);
    #1;
    chk({tag, ".rs1_read"}, {31'd0, cu_bus.rs1_read}, {31'd0, er1});
    chk({tag, ".rs2_read"}, {31'd0, cu_bus.rs2_read}, {31'd0, er2});
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() != 0)
    else begin
      failures++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      got = sb.pop_front();
      chk({got.tag, ".next_pc"}, cu_bus.next_pc, got.npc);
      chk({got.tag, ".pc_j_valid"}, {31'd0, cu_bus.pc_j_valid}, {31'd0, got.jv});
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;

    // Reset with a taken BEQ present: reset must win.
    step("reset", bit_of(27), 32'd1, 32'd1, 32'd1, 1'b1, 1'b1, 32'd5, 32'd0, 1'b0, 1'b1, 1'b1);
    rst_n = 1'b1;

    step("beq_taken", bit_of(27), 32'd1, 32'd1, 32'd1, 1'b1, 1'b1, 32'd5,
         32'd6, 1'b1, 1'b1, 1'b1);
    step("beq_not_taken", bit_of(27), 32'd1, 32'd1, 32'd2, 1'b1, 1'b1, 32'd5,
         32'd5, 1'b0, 1'b1, 1'b1);
    step("blt", bit_of(29), 32'd100, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 32'hFFFF_FFF8,
         32'd92, 1'b1, 1'b1, 1'b1);
    step("bltu", bit_of(31), 32'd100, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 32'hFFFF_FFF8,
         32'd104, 1'b0, 1'b1, 1'b1);
    step("bge", bit_of(30), 32'd100, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 32'd20,
         32'd104, 1'b0, 1'b1, 1'b1);
    step("bgeu", bit_of(32), 32'd100, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 32'd20,
         32'd120, 1'b1, 1'b1, 1'b1);
    step("jalr", bit_of(34), 32'd500, 32'h0000_1003, 32'd0, 1'b1, 1'b0, 32'd4,
         32'h0000_1006, 1'b1, 1'b1, 1'b0);
    step("jal", bit_of(33), 32'h200, 32'd0, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFF0,
         32'h1F0, 1'b1, 1'b0, 1'b0);
    step("bne_stall", bit_of(28), 32'd40, 32'd3, 32'd5, 1'b1, 1'b0, 32'd12,
         32'd40, 1'b0, 1'b1, 1'b1);
    step("bne_resume", bit_of(28), 32'd40, 32'd3, 32'd5, 1'b1, 1'b1, 32'd12,
         32'd52, 1'b1, 1'b1, 1'b1);
    step("sw_stall", bit_of(26), 32'd60, 32'd3, 32'd5, 1'b1, 1'b0, 32'd8,
         32'd60, 1'b0, 1'b1, 1'b1);
    step("addi", bit_of(10), 32'd8, 32'd7, 32'd0, 1'b1, 1'b0, 32'd3,
         32'd12, 1'b0, 1'b1, 1'b0);
    step("zero_bus", 37'd0, 32'd8, 32'd7, 32'd0, 1'b0, 1'b0, 32'd3,
         32'd12, 1'b0, 1'b0, 1'b0);
    step("multi_hot", bit_of(27) | bit_of(33), 32'd8, 32'd1, 32'd1, 1'b1, 1'b1, 32'd40,
         32'd12, 1'b0, 1'b0, 1'b0);
    step("lui", bit_of(35), 32'd16, 32'd0, 32'd0, 1'b0, 1'b0, 32'h1000,
         32'd20, 1'b0, 1'b0, 1'b0);
    step("pc_wrap", bit_of(36), 32'hFFFF_FFFC, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0,
         32'd0, 1'b0, 1'b0, 1'b0);

    // Reset asserted while the instruction is stalled.
    rst_n = 1'b0;
    step("reset_mid_stall", bit_of(28), 32'd40, 32'd3, 32'd5, 1'b1, 1'b0, 32'd12,
         32'd0, 1'b0, 1'b1, 1'b1);
    rst_n = 1'b1;
    step("post_reset_sub", bit_of(1), 32'd24, 32'd3, 32'd5, 1'b1, 1'b1, 32'd0,
         32'd28, 1'b0, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
